// File: rtl/hydra_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hydra_axi_pkg
// Description : SNOC AXI channel payloads and the bundled request/response
//               structs (snoc_req_s / snoc_resp_s) shared by SNOC blocks.
// Revision    : 1.0  initial release
// ============================================================================
package hydra_axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
  } axi_ax_s;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } axi_w_s;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_s;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_s;

  // Master -> slave direction
  typedef struct packed {
    logic    ar_valid;
    axi_ax_s ar;
    logic    aw_valid;
    axi_ax_s aw;
    logic    w_valid;
    axi_w_s  w;
    logic    r_ready;
    logic    b_ready;
  } snoc_req_s;

  // Slave -> master direction
  typedef struct packed {
    logic   ar_ready;
    logic   aw_ready;
    logic   w_ready;
    logic   r_valid;
    axi_r_s r;
    logic   b_valid;
    axi_b_s b;
  } snoc_resp_s;

endpackage
`default_nettype wire

// File: rtl/snoc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snoc_arb_pkg
// Description : State encodings, grant index type and pointer helper for the
//               SNOC AXI round-robin arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package snoc_arb_pkg;

  localparam int SNOC_ARB_MAX_MST = 8;

  // Index wide enough for the largest supported requester count
  typedef logic [$clog2(SNOC_ARB_MAX_MST)-1:0] gnt_idx_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  // Pointer moves to the requester after the one just served, wrapping at n-1
  function automatic gnt_idx_t snoc_arb_next_ptr(input gnt_idx_t g, input int n);
    if (int'(g) >= n - 1) begin
      return '0;
    end
    return g + gnt_idx_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoc_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : snoc_rr_sel
// Description : Combinational round-robin winner select. Searches req starting
//               at ptr, wrapping past N-1 to 0; first set bit wins.
// Ports       : req     in  N   request vector
//               ptr     in      highest-priority index
//               gnt_oh  out N   one-hot winner (0 when no request)
//               gnt_idx out     winner index
//               any     out 1   at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module snoc_rr_sel
  import snoc_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  gnt_idx_t     ptr,
  output logic [N-1:0] gnt_oh,
  output gnt_idx_t     gnt_idx,
  output logic         any
);

  logic [N-1:0] w_hi;   // requests at or above ptr
  logic [N-1:0] w_src;  // vector the lowest-bit search runs on

  always_comb begin
    w_hi    = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = |req;
    for (int i = 0; i < N; i++) begin
      w_hi[i] = req[i] && (i >= int'(ptr));
    end
    // Nothing at/above ptr means the search wraps to the bottom of req
    w_src = (|w_hi) ? w_hi : req;
    // Descending scan so the lowest set index is the final assignment
    for (int i = N - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_idx   = gnt_idx_t'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snoc_axi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : snoc_axi_rr_arb
// Description : N-to-1 arbiter sharing one SNOC AXI master port. Read and
//               write paths arbitrate independently, round-robin, one
//               outstanding transaction per path, no ID remapping.
//               Optional watchdog enabled by `define SNOC_ARB_TIMEOUT_EN.
// Ports       : clk, rst     clock / synchronous active-high reset
//               s_req_i      in  N_MST upstream requests
//               s_resp_o     out N_MST upstream responses
//               m_req_o      out downstream request
//               m_resp_i     in  downstream response
//               rd_gnt_o     out one-hot read grant (0 when idle)
//               wr_gnt_o     out one-hot write grant (0 when idle)
//               timeout_o    out sticky watchdog flag (SNOC_ARB_TIMEOUT_EN)
// Revision    : 1.0  initial release
// ============================================================================
module snoc_axi_rr_arb
  import hydra_axi_pkg::*;
  import snoc_arb_pkg::*;
#(
  parameter int N_MST       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  snoc_req_s  [N_MST-1:0]  s_req_i,
  output snoc_resp_s [N_MST-1:0]  s_resp_o,
  output snoc_req_s               m_req_o,
  input  snoc_resp_s              m_resp_i,
  output logic       [N_MST-1:0]  rd_gnt_o,
`ifdef SNOC_ARB_TIMEOUT_EN
  output logic                    timeout_o,
`endif
  output logic       [N_MST-1:0]  wr_gnt_o
);

  if (N_MST < 2 || N_MST > SNOC_ARB_MAX_MST || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("snoc_axi_rr_arb: N_MST must be 2..8 and TIMEOUT_CYC >= 1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  rd_state_e            r_rd_st, w_rd_st_nxt;
  wr_state_e            r_wr_st, w_wr_st_nxt;
  gnt_idx_t             r_rd_g, r_wr_g;      // index of current/last holder
  gnt_idx_t             r_rd_ptr, r_wr_ptr;  // round-robin priority pointer
  logic     [N_MST-1:0] r_rd_gnt, r_wr_gnt;

  logic     [N_MST-1:0] w_ar_req, w_aw_req;
  logic     [N_MST-1:0] w_rd_sel_oh, w_wr_sel_oh;
  gnt_idx_t             w_rd_sel_idx, w_wr_sel_idx;
  logic                 w_rd_any, w_wr_any;

  // Fields of the selected requester (mux on registered index)
  axi_ax_s w_rd_ar, w_wr_aw;
  axi_w_s  w_wr_w;
  logic    w_rd_ar_valid, w_rd_r_ready;
  logic    w_wr_aw_valid, w_wr_w_valid, w_wr_b_ready;

  logic    w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

  // --------------------------------------------------------------------------
  // Request vectors and grant-holder mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_ar_req      = '0;
    w_aw_req      = '0;
    w_rd_ar       = '0;
    w_rd_ar_valid = 1'b0;
    w_rd_r_ready  = 1'b0;
    w_wr_aw       = '0;
    w_wr_aw_valid = 1'b0;
    w_wr_w        = '0;
    w_wr_w_valid  = 1'b0;
    w_wr_b_ready  = 1'b0;
    for (int i = 0; i < N_MST; i++) begin
      w_ar_req[i] = s_req_i[i].ar_valid;
      w_aw_req[i] = s_req_i[i].aw_valid;
      if (r_rd_g == gnt_idx_t'(i)) begin
        w_rd_ar       = s_req_i[i].ar;
        w_rd_ar_valid = s_req_i[i].ar_valid;
        w_rd_r_ready  = s_req_i[i].r_ready;
      end
      if (r_wr_g == gnt_idx_t'(i)) begin
        w_wr_aw       = s_req_i[i].aw;
        w_wr_aw_valid = s_req_i[i].aw_valid;
        w_wr_w        = s_req_i[i].w;
        w_wr_w_valid  = s_req_i[i].w_valid;
        w_wr_b_ready  = s_req_i[i].b_ready;
      end
    end
  end

  snoc_rr_sel #(.N(N_MST)) u_rd_sel (
    .req     (w_ar_req),
    .ptr     (r_rd_ptr),
    .gnt_oh  (w_rd_sel_oh),
    .gnt_idx (w_rd_sel_idx),
    .any     (w_rd_any)
  );

  snoc_rr_sel #(.N(N_MST)) u_wr_sel (
    .req     (w_aw_req),
    .ptr     (r_wr_ptr),
    .gnt_oh  (w_wr_sel_oh),
    .gnt_idx (w_wr_sel_idx),
    .any     (w_wr_any)
  );

  // --------------------------------------------------------------------------
  // Downstream request: payload always from holder, valids gated by state
  // --------------------------------------------------------------------------
  always_comb begin
    m_req_o          = '0;
    m_req_o.ar       = w_rd_ar;
    m_req_o.ar_valid = (r_rd_st == R_ADDR) && w_rd_ar_valid;
    m_req_o.r_ready  = (r_rd_st == R_DATA) && w_rd_r_ready;
    m_req_o.aw       = w_wr_aw;
    m_req_o.aw_valid = (r_wr_st == W_ADDR) && w_wr_aw_valid;
    m_req_o.w        = w_wr_w;
    m_req_o.w_valid  = (r_wr_st == W_DATA) && w_wr_w_valid;
    m_req_o.b_ready  = (r_wr_st == W_RESP) && w_wr_b_ready;
  end

  assign w_ar_hs = m_req_o.ar_valid && m_resp_i.ar_ready;
  assign w_r_hs  = m_resp_i.r_valid && m_req_o.r_ready;
  assign w_aw_hs = m_req_o.aw_valid && m_resp_i.aw_ready;
  assign w_w_hs  = m_req_o.w_valid  && m_resp_i.w_ready;
  assign w_b_hs  = m_resp_i.b_valid && m_req_o.b_ready;

  // --------------------------------------------------------------------------
  // Upstream responses: only the grant holder sees anything non-zero
  // --------------------------------------------------------------------------
  always_comb begin
    s_resp_o = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (r_rd_gnt[i]) begin
        s_resp_o[i].ar_ready = (r_rd_st == R_ADDR) && m_resp_i.ar_ready;
        s_resp_o[i].r_valid  = (r_rd_st == R_DATA) && m_resp_i.r_valid;
        s_resp_o[i].r        = m_resp_i.r;
      end
      if (r_wr_gnt[i]) begin
        s_resp_o[i].aw_ready = (r_wr_st == W_ADDR) && m_resp_i.aw_ready;
        s_resp_o[i].w_ready  = (r_wr_st == W_DATA) && m_resp_i.w_ready;
        s_resp_o[i].b_valid  = (r_wr_st == W_RESP) && m_resp_i.b_valid;
        s_resp_o[i].b        = m_resp_i.b;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_st_nxt = r_rd_st;
    case (r_rd_st)
      R_IDLE:  if (w_rd_any) w_rd_st_nxt = R_ADDR;
      R_ADDR:  if (w_ar_hs) w_rd_st_nxt = R_DATA;
      R_DATA:  if (w_r_hs && m_resp_i.r.last) w_rd_st_nxt = R_IDLE;
      default: w_rd_st_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_st  <= R_IDLE;
      r_rd_g   <= '0;
      r_rd_gnt <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_rd_st <= w_rd_st_nxt;
      if (r_rd_st == R_IDLE && w_rd_any) begin
        r_rd_g   <= w_rd_sel_idx;
        r_rd_gnt <= w_rd_sel_oh;
      end
      if (r_rd_st == R_DATA && w_rd_st_nxt == R_IDLE) begin
        r_rd_gnt <= '0;
        r_rd_ptr <= snoc_arb_next_ptr(r_rd_g, N_MST);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_st_nxt = r_wr_st;
    case (r_wr_st)
      W_IDLE:  if (w_wr_any) w_wr_st_nxt = W_ADDR;
      W_ADDR:  if (w_aw_hs) w_wr_st_nxt = W_DATA;
      W_DATA:  if (w_w_hs && m_req_o.w.last) w_wr_st_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wr_st_nxt = W_IDLE;
      default: w_wr_st_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_st  <= W_IDLE;
      r_wr_g   <= '0;
      r_wr_gnt <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_wr_st <= w_wr_st_nxt;
      if (r_wr_st == W_IDLE && w_wr_any) begin
        r_wr_g   <= w_wr_sel_idx;
        r_wr_gnt <= w_wr_sel_oh;
      end
      if (r_wr_st == W_RESP && w_wr_st_nxt == W_IDLE) begin
        r_wr_gnt <= '0;
        r_wr_ptr <= snoc_arb_next_ptr(r_wr_g, N_MST);
      end
    end
  end

  assign rd_gnt_o = r_rd_gnt;
  assign wr_gnt_o = r_wr_gnt;

`ifdef SNOC_ARB_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Watchdog: counts cycles without progress on each busy path. Only raises a
  // flag; the FSMs keep waiting for the real response.
  // --------------------------------------------------------------------------
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_rd_cnt, r_wr_cnt;
  logic          r_timeout;
  logic          w_rd_clr, w_wr_clr;

  assign w_rd_clr = (r_rd_st == R_IDLE) || w_ar_hs || w_r_hs;
  assign w_wr_clr = (r_wr_st == W_IDLE) || w_aw_hs || w_w_hs || w_b_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_rd_clr) begin
        r_rd_cnt <= '0;
      end else if (r_rd_cnt != CW'(TIMEOUT_CYC)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_wr_clr) begin
        r_wr_cnt <= '0;
      end else if (r_wr_cnt != CW'(TIMEOUT_CYC)) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (r_rd_cnt == CW'(TIMEOUT_CYC) || r_wr_cnt == CW'(TIMEOUT_CYC)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snoc_axi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoc_axi_rr_arb
// Description : Directed self-checking bench for snoc_axi_rr_arb with two
//               requesters. Watchdog scenario runs when SNOC_ARB_TIMEOUT_EN
//               is defined (TIMEOUT_CYC=16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_snoc_axi_rr_arb;
  import hydra_axi_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  snoc_req_s  [N-1:0] s_req;
  snoc_resp_s [N-1:0] s_resp;
  snoc_req_s          m_req;
  snoc_resp_s         m_resp;
  logic       [N-1:0] rd_gnt;
  logic       [N-1:0] wr_gnt;
`ifdef SNOC_ARB_TIMEOUT_EN
  logic               timeout;
`endif

  int total = 0;
  int bad   = 0;
  int ar_cnt = 0;
  int b_cnt0 = 0;
  int b_cnt1 = 0;

  always #5 clk = ~clk;

  snoc_axi_rr_arb #(.N_MST(N), .TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_req_i  (s_req),
    .s_resp_o (s_resp),
    .m_req_o  (m_req),
    .m_resp_i (m_resp),
    .rd_gnt_o (rd_gnt),
`ifdef SNOC_ARB_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .wr_gnt_o (wr_gnt)
  );

  // Handshake counters observed at the clock edge
  always @(posedge clk) begin
    if (!rst && m_req.ar_valid && m_resp.ar_ready) ar_cnt++;
    if (!rst && s_resp[0].b_valid && s_req[0].b_ready) b_cnt0++;
    if (!rst && s_resp[1].b_valid && s_req[1].b_ready) b_cnt1++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst    = 1'b1;
    s_req  = '0;
    m_resp = '0;
    tick;
    tick;
    rst    = 1'b0;
    ar_cnt = 0;
    b_cnt0 = 0;
    b_cnt1 = 0;
  endtask

  // Downstream accepts the pending AR of master m (FSM must be in R_ADDR)
  task automatic accept_ar(input int m);
    m_resp.ar_ready = 1'b1;
    tick;
    s_req[m].ar_valid = 1'b0;
    m_resp.ar_ready   = 1'b0;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    s_req  = '0;
    m_resp = '0;
    s_req[0].ar_valid = 1'b1;
    s_req[1].aw_valid = 1'b1;
    m_resp.r_valid    = 1'b1;
    m_resp.b_valid    = 1'b1;
    tick;
    tick;
    #1;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("FAIL reset_rd_gnt: got %b want 00", rd_gnt); end
    total++; if (wr_gnt !== 2'b00) begin bad++; $display("FAIL reset_wr_gnt: got %b want 00", wr_gnt); end
    total++; if ({m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.r_ready, m_req.b_ready} !== 5'b0) begin
      bad++; $display("FAIL reset_m_req_handshake: got %b want 00000",
                      {m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.r_ready, m_req.b_ready});
    end
    total++; if (s_resp !== '0) begin bad++; $display("FAIL reset_s_resp: got %h want 0", s_resp); end
    do_reset;
  endtask

  task automatic test_single_read;
    do_reset;
    s_req[0].ar.id    = 4'h1;
    s_req[0].ar.addr  = 32'h100;
    s_req[0].ar.len   = 8'd3;
    s_req[0].ar_valid = 1'b1;
    s_req[0].r_ready  = 1'b1;
    s_req[1].r_ready  = 1'b1;
    #1;
    total++; if (m_req.ar_valid !== 1'b0) begin bad++; $display("FAIL rd_arb_latency: got ar_valid=%b want 0", m_req.ar_valid); end
    tick;
    total++; if (rd_gnt !== 2'b01) begin bad++; $display("FAIL rd_grant_m0: got %b want 01", rd_gnt); end
    total++; if (m_req.ar_valid !== 1'b1 || m_req.ar.addr !== 32'h100 || m_req.ar.len !== 8'd3) begin
      bad++; $display("FAIL rd_ar_fwd: got v=%b addr=%h len=%0d want v=1 addr=100 len=3",
                      m_req.ar_valid, m_req.ar.addr, m_req.ar.len);
    end
    m_resp.ar_ready = 1'b1;
    #1;
    total++; if (s_resp[0].ar_ready !== 1'b1 || s_resp[1].ar_ready !== 1'b0) begin
      bad++; $display("FAIL rd_ar_ready_route: got m0=%b m1=%b want m0=1 m1=0", s_resp[0].ar_ready, s_resp[1].ar_ready);
    end
    tick;
    s_req[0].ar_valid = 1'b0;
    m_resp.ar_ready   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_resp.r_valid  = 1'b1;
      m_resp.r.data   = 32'h1000 + k;
      m_resp.r.id     = 4'h1;
      m_resp.r.last   = (k == 3);
      #1;
      total++; if (s_resp[0].r_valid !== 1'b1 || s_resp[0].r.data !== 32'h1000 + k) begin
        bad++; $display("FAIL rd_beat%0d_m0: got v=%b data=%h want v=1 data=%h", k, s_resp[0].r_valid, s_resp[0].r.data, 32'h1000 + k);
      end
      total++; if (s_resp[1].r_valid !== 1'b0) begin bad++; $display("FAIL rd_beat%0d_m1_quiet: got %b want 0", k, s_resp[1].r_valid); end
      tick;
    end
    m_resp.r_valid = 1'b0;
    m_resp.r.last  = 1'b0;
    #1;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("FAIL rd_gnt_release: got %b want 00", rd_gnt); end
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL rd_ar_count: got %0d want 1", ar_cnt); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_gnt;
    logic [31:0] exp_addr;
    int e;
    do_reset;
    s_req[0].ar.addr = 32'h10;
    s_req[1].ar.addr = 32'h20;
    s_req[0].r_ready = 1'b1;
    s_req[1].r_ready = 1'b1;
    s_req[0].ar_valid = 1'b1;
    s_req[1].ar_valid = 1'b1;
    // Both always requesting: winner must alternate m0, m1, m0, m1
    for (int rnd = 0; rnd < 4; rnd++) begin
      e        = rnd % 2;
      exp_gnt  = (e == 0) ? 2'b01 : 2'b10;
      exp_addr = (e == 0) ? 32'h10 : 32'h20;
      tick;
      total++; if (rd_gnt !== exp_gnt || m_req.ar.addr !== exp_addr) begin
        bad++; $display("FAIL rr_round%0d: got gnt=%b addr=%h want gnt=%b addr=%h", rnd, rd_gnt, m_req.ar.addr, exp_gnt, exp_addr);
      end
      accept_ar(e);
      s_req[e].ar_valid = 1'b1;  // immediately requests again
      m_resp.r_valid = 1'b1;
      m_resp.r.last  = 1'b1;
      #1;
      total++; if (s_resp[e].r_valid !== 1'b1 || s_resp[1-e].r_valid !== 1'b0) begin
        bad++; $display("FAIL rr_round%0d_r_route: got m0=%b m1=%b want only m%0d", rnd, s_resp[0].r_valid, s_resp[1].r_valid, e);
      end
      tick;
      m_resp.r_valid = 1'b0;
      m_resp.r.last  = 1'b0;
    end
  endtask

  task automatic test_concurrent;
    do_reset;
    s_req[0].ar.addr  = 32'h200;
    s_req[0].ar.len   = 8'd0;
    s_req[0].ar_valid = 1'b1;
    s_req[0].r_ready  = 1'b1;
    s_req[1].aw.addr  = 32'h300;
    s_req[1].aw.len   = 8'd1;
    s_req[1].aw_valid = 1'b1;
    s_req[1].b_ready  = 1'b1;
    s_req[0].b_ready  = 1'b1;
    tick;
    total++; if (rd_gnt !== 2'b01 || wr_gnt !== 2'b10) begin
      bad++; $display("FAIL conc_grants: got rd=%b wr=%b want rd=01 wr=10", rd_gnt, wr_gnt);
    end
    m_resp.ar_ready = 1'b1;
    m_resp.aw_ready = 1'b1;
    tick;
    s_req[0].ar_valid = 1'b0;
    s_req[1].aw_valid = 1'b0;
    m_resp.ar_ready   = 1'b0;
    m_resp.aw_ready   = 1'b0;
    s_req[1].w_valid  = 1'b1;
    s_req[1].w.data   = 32'hA5A5;
    s_req[1].w.last   = 1'b0;
    m_resp.w_ready    = 1'b1;
    m_resp.r_valid    = 1'b1;
    m_resp.r.data     = 32'hCAFE;
    m_resp.r.last     = 1'b1;
    #1;
    total++; if (m_req.w_valid !== 1'b1 || m_req.w.data !== 32'hA5A5) begin
      bad++; $display("FAIL conc_w0: got v=%b data=%h want v=1 data=0000a5a5", m_req.w_valid, m_req.w.data);
    end
    total++; if (s_resp[0].r_valid !== 1'b1 || s_resp[1].r_valid !== 1'b0 || s_resp[0].w_ready !== 1'b0 || s_resp[1].w_ready !== 1'b1) begin
      bad++; $display("FAIL conc_route: got r0=%b r1=%b wr0=%b wr1=%b want 1 0 0 1",
                      s_resp[0].r_valid, s_resp[1].r_valid, s_resp[0].w_ready, s_resp[1].w_ready);
    end
    tick;
    m_resp.r_valid  = 1'b0;
    m_resp.r.last   = 1'b0;
    s_req[1].w.data = 32'h5A5A;
    s_req[1].w.last = 1'b1;
    #1;
    total++; if (m_req.w.data !== 32'h5A5A || m_req.w.last !== 1'b1) begin
      bad++; $display("FAIL conc_w1: got data=%h last=%b want 00005a5a 1", m_req.w.data, m_req.w.last);
    end
    tick;
    s_req[1].w_valid = 1'b0;
    m_resp.w_ready   = 1'b0;
    m_resp.b_valid   = 1'b1;
    #1;
    total++; if (s_resp[1].b_valid !== 1'b1 || s_resp[0].b_valid !== 1'b0 || rd_gnt !== 2'b00) begin
      bad++; $display("FAIL conc_b_route: got b0=%b b1=%b rd_gnt=%b want 0 1 00", s_resp[0].b_valid, s_resp[1].b_valid, rd_gnt);
    end
    tick;
    m_resp.b_valid = 1'b0;
    #1;
    total++; if (wr_gnt !== 2'b00 || b_cnt1 !== 1 || b_cnt0 !== 0) begin
      bad++; $display("FAIL conc_w_done: got wr_gnt=%b b1=%0d b0=%0d want 00 1 0", wr_gnt, b_cnt1, b_cnt0);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d [4];
    logic        rdy;
    int          beat;
    d[0] = 32'h0000_1111;
    d[1] = 32'h0000_2222;
    d[2] = 32'h0000_3333;
    d[3] = 32'h0000_4444;
    do_reset;
    s_req[1].aw.addr  = 32'h400;
    s_req[1].aw.len   = 8'd3;
    s_req[1].aw_valid = 1'b1;
    s_req[1].b_ready  = 1'b1;
    s_req[0].b_ready  = 1'b1;
    tick;
    total++; if (wr_gnt !== 2'b10) begin bad++; $display("FAIL bp_grant: got %b want 10", wr_gnt); end
    m_resp.aw_ready = 1'b1;
    tick;
    s_req[1].aw_valid = 1'b0;
    m_resp.aw_ready   = 1'b0;
    beat = 0;
    // Downstream ready for beats 0,1, stalls 5 cycles, then takes beats 2,3
    for (int c = 0; c < 9; c++) begin
      rdy = !(c >= 2 && c < 7);
      s_req[1].w_valid = 1'b1;
      s_req[1].w.data  = d[beat];
      s_req[1].w.last  = (beat == 3);
      m_resp.w_ready   = rdy;
      #1;
      total++; if (s_resp[1].w_ready !== rdy || s_resp[0].w_ready !== 1'b0 || m_req.w.data !== d[beat]) begin
        bad++; $display("FAIL bp_cycle%0d: got wr1=%b wr0=%b data=%h want wr1=%b wr0=0 data=%h",
                        c, s_resp[1].w_ready, s_resp[0].w_ready, m_req.w.data, rdy, d[beat]);
      end
      tick;
      if (rdy) beat++;
    end
    s_req[1].w_valid = 1'b0;
    s_req[1].w.last  = 1'b0;
    m_resp.w_ready   = 1'b0;
    m_resp.b_valid   = 1'b1;
    #1;
    total++; if (s_resp[1].b_valid !== 1'b1 || s_resp[0].b_valid !== 1'b0) begin
      bad++; $display("FAIL bp_b_route: got b1=%b b0=%b want 1 0", s_resp[1].b_valid, s_resp[0].b_valid);
    end
    tick;
    m_resp.b_valid = 1'b0;
    #1;
    total++; if (b_cnt1 !== 1 || b_cnt0 !== 0 || wr_gnt !== 2'b00) begin
      bad++; $display("FAIL bp_b_count: got b1=%0d b0=%0d wr_gnt=%b want 1 0 00", b_cnt1, b_cnt0, wr_gnt);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    s_req[0].r_ready = 1'b1;
    s_req[1].r_ready = 1'b1;
    // Complete one m0 read so the pointer moves off 0
    s_req[0].ar.addr  = 32'h500;
    s_req[0].ar.len   = 8'd0;
    s_req[0].ar_valid = 1'b1;
    tick;
    accept_ar(0);
    m_resp.r_valid = 1'b1;
    m_resp.r.last  = 1'b1;
    tick;
    // Start a 4-beat m0 read and abandon it after 2 beats
    s_req[0].ar.len   = 8'd3;
    s_req[0].ar_valid = 1'b1;
    m_resp.r_valid    = 1'b0;
    m_resp.r.last     = 1'b0;
    tick;
    accept_ar(0);
    m_resp.r_valid = 1'b1;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    total++; if (rd_gnt !== 2'b00 || m_req.r_ready !== 1'b0 || s_resp[0].r_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle: got gnt=%b r_ready=%b r_valid0=%b want 00 0 0", rd_gnt, m_req.r_ready, s_resp[0].r_valid);
    end
    m_resp.r_valid = 1'b0;
    // Both request: pointer back at 0 means m0 wins first
    s_req[0].ar.len   = 8'd0;
    s_req[0].ar_valid = 1'b1;
    s_req[1].ar.addr  = 32'h600;
    s_req[1].ar.len   = 8'd0;
    s_req[1].ar_valid = 1'b1;
    tick;
    total++; if (rd_gnt !== 2'b01) begin bad++; $display("FAIL rstmid_ptr: got %b want 01", rd_gnt); end
    accept_ar(0);
    m_resp.r_valid = 1'b1;
    m_resp.r.last  = 1'b1;
    tick;
    m_resp.r_valid = 1'b0;
    m_resp.r.last  = 1'b0;
    tick;
    total++; if (rd_gnt !== 2'b10 || m_req.ar.addr !== 32'h600 || m_req.ar_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_m1_grant: got gnt=%b addr=%h v=%b want 10 600 1", rd_gnt, m_req.ar.addr, m_req.ar_valid);
    end
    accept_ar(1);
    m_resp.r_valid = 1'b1;
    m_resp.r.data  = 32'hBEEF;
    m_resp.r.last  = 1'b1;
    #1;
    total++; if (s_resp[1].r_valid !== 1'b1 || s_resp[1].r.data !== 32'hBEEF || s_resp[0].r_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_m1_data: got v1=%b data=%h v0=%b want 1 beef 0", s_resp[1].r_valid, s_resp[1].r.data, s_resp[0].r_valid);
    end
    tick;
    m_resp.r_valid = 1'b0;
    m_resp.r.last  = 1'b0;
  endtask

`ifdef SNOC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    #1;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_reset: got %b want 0", timeout); end
    s_req[0].ar_valid = 1'b1;
    s_req[0].r_ready  = 1'b1;
    tick;
    accept_ar(0);
    repeat (5) tick;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout); end
    repeat (15) tick;
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", timeout); end
    m_resp.r_valid = 1'b1;
    m_resp.r.last  = 1'b1;
    tick;
    m_resp.r_valid = 1'b0;
    m_resp.r.last  = 1'b0;
    tick;
    total++; if (timeout !== 1'b1 || rd_gnt !== 2'b00) begin
      bad++; $display("FAIL to_sticky: got timeout=%b gnt=%b want 1 00", timeout, rd_gnt);
    end
  endtask
`endif

  initial begin
    s_req  = '0;
    m_resp = '0;
    test_reset;
    test_single_read;
    test_contention;
    test_concurrent;
    test_backpressure;
    test_reset_mid;
`ifdef SNOC_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
